// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: deframes RX_IN into bytes using 3-sample majority voting,
// optional even/odd parity, and start-glitch rejection. Strobes appear one cycle after the frame ends.
module uart_rx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      STP_ERR
);

    localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_WIDTH-1:0]  LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_WIDTH-1:0]  BIT_ONE  = BIT_CNT_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, next_state;

    logic [PRESCALE_WIDTH-1:0] presc, presc_sel, half, edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_en, par_typ, sample_a, sample_b, par_mis, stop_bit;
    logic                      start_det, at_last, at_vote, vote;
    logic                      frame_done, valid_nxt, par_err_nxt, stp_err_nxt;

    // Anything other than 16 or 32 runs at 8x oversampling.
    always_comb begin
        presc_sel = PRESCALE_WIDTH'(8);
        if (PRESCALE == PRESCALE_WIDTH'(16) || PRESCALE == PRESCALE_WIDTH'(32))
            presc_sel = PRESCALE;
    end

    assign half      = presc >> 1;
    assign start_det = (state == IDLE) && !RX_IN;
    assign at_last   = (state != IDLE) && (edge_cnt == presc - ONE);
    assign at_vote   = (state != IDLE) && (edge_cnt == half + ONE);
    assign vote      = (sample_a & sample_b) | (sample_a & RX_IN) | (sample_b & RX_IN);

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN) next_state = START;
            START: begin
                if (at_vote && vote)
                    next_state = IDLE;
                else if (at_last)
                    next_state = DATA;
            end
            DATA:    if (at_last && bit_cnt == LAST_BIT) next_state = par_en ? PARITY : STOP;
            PARITY:  if (at_last) next_state = STOP;
            STOP:    if (at_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        frame_done  = (state == STOP) && at_last;
        par_err_nxt = frame_done && par_mis;
        stp_err_nxt = frame_done && !stop_bit;
        valid_nxt   = frame_done && !par_mis && stop_bit;
    end

    // The start-detect cycle is edge 0 of the start bit, so counting resumes at 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            presc      <= '0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_en     <= 1'b0;
            par_typ    <= 1'b0;
            sample_a   <= 1'b0;
            sample_b   <= 1'b0;
            par_mis    <= 1'b0;
            stop_bit   <= 1'b0;
        end else begin
            DATA_VALID <= valid_nxt;
            PAR_ERR    <= par_err_nxt;
            STP_ERR    <= stp_err_nxt;
            if (valid_nxt)
                P_DATA <= shift_reg;
            if (start_det) begin
                presc    <= presc_sel;
                par_en   <= PAR_EN;
                par_typ  <= PAR_TYP;
                edge_cnt <= ONE;
                bit_cnt  <= '0;
                par_mis  <= 1'b0;
                stop_bit <= 1'b0;
            end else if (state != IDLE) begin
                edge_cnt <= (at_last || next_state == IDLE) ? '0 : edge_cnt + ONE;
                if (edge_cnt == half - ONE)
                    sample_a <= RX_IN;
                if (edge_cnt == half)
                    sample_b <= RX_IN;
                if (at_vote) begin
                    case (state)
                        DATA:    shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
                        PARITY:  par_mis   <= (vote != ((^shift_reg) ^ par_typ));
                        STOP:    stop_bit  <= vote;
                        default: ;
                    endcase
                end
                if (state == DATA && at_last)
                    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed and random frames, each predicted as one strobe event
// at T0 + N*P; a per-cycle compare process checks strobes and P_DATA against that prediction.
module tb_uart_rx_frame;

    logic       CLK = 1'b0;
    logic       RST, RX_IN, PAR_EN, PAR_TYP;
    logic [5:0] PRESCALE;
    logic [7:0] P_DATA;
    logic       DATA_VALID, PAR_ERR, STP_ERR;

    uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .PRESCALE(PRESCALE), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         when;
        logic       valid;
        logic       perr;
        logic       serr;
        logic [7:0] data;
    } exp_t;

    int         cyc = 0;
    logic       rst_q = 1'b1;
    exp_t       exp_q[$];
    int         valid_times[$];
    logic [7:0] model_pdata = 8'h00;
    int         pass_cnt = 0, total_cnt = 0;
    bit         checking = 1'b0;

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= RST;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_out(input string name, input logic dv, input logic pe, input logic se,
                              input logic [7:0] pd);
        check({name, "_strobes"}, 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'({dv, pe, se}));
        check({name, "_p_data"}, 32'(P_DATA), 32'(pd));
    endtask

    // Outputs are compared mid-cycle, away from the sampling edge.
    always @(negedge CLK) begin
        exp_t e;
        logic ev, pe, se;
        if (checking) begin
            ev = 1'b0; pe = 1'b0; se = 1'b0;
            if (rst_q) begin
                exp_q.delete();
                model_pdata = 8'h00;
            end else if (exp_q.size() > 0 && exp_q[0].when == cyc) begin
                e  = exp_q.pop_front();
                ev = e.valid; pe = e.perr; se = e.serr;
                if (e.valid)
                    model_pdata = e.data;
            end
            check("cycle_strobes", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'({ev, pe, se}));
            check("cycle_p_data", 32'(P_DATA), 32'(model_pdata));
            if (DATA_VALID)
                valid_times.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    // Drives one frame; abort_bit >= 0 pulses RST mid-way through that bit position instead.
    task automatic send_frame(input logic [7:0] d, input int p_in, input logic pe, input logic pt,
                              input logic flip_par, input logic stop_v, input bit scramble,
                              input int abort_bit);
        logic [10:0] bits;
        int          n, eff;
        exp_t        e;
        eff  = (p_in == 8 || p_in == 16 || p_in == 32) ? p_in : 8;
        n    = 10 + int'(pe);
        bits = '0;
        bits[8:1] = d;
        if (pe) begin
            bits[9]  = (^d) ^ pt ^ flip_par;
            bits[10] = stop_v;
        end else begin
            bits[9] = stop_v;
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < eff; j++) begin
                @(negedge CLK);
                if (abort_bit == i && j == eff / 2) begin
                    RST = 1'b1;
                    @(negedge CLK);
                    RST   = 1'b0;
                    RX_IN = 1'b1;
                    return;
                end
                if (i == 0 && j == 0) begin
                    PRESCALE = 6'(p_in);
                    PAR_EN   = pe;
                    PAR_TYP  = pt;
                    if (abort_bit < 0) begin
                        e.when  = cyc + n * eff;
                        e.perr  = pe && (bits[9] != ((^d) ^ pt));
                        e.serr  = !bits[n-1];
                        e.valid = !e.perr && !e.serr;
                        e.data  = d;
                        exp_q.push_back(e);
                    end
                end else if (scramble) begin
                    PRESCALE = 6'($urandom);
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                end
                RX_IN = bits[i];
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] glitch_pat;
        int         n;
        int         presc_tab[8];
        presc_tab = '{8, 16, 32, 8, 16, 32, 12, 0};

        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 6'd8;
        repeat (3) @(negedge CLK);
        checking = 1'b1;
        expect_out("reset", 1'b0, 1'b0, 1'b0, 8'h00);
        RST = 1'b0;
        idle(4);

        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        @(negedge CLK); RX_IN = 1'b1;
        expect_out("a5_p8", 1'b1, 1'b0, 1'b0, 8'hA5);
        idle(5);

        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        @(negedge CLK); RX_IN = 1'b1;
        expect_out("3c_even_ok", 1'b1, 1'b0, 1'b0, 8'h3C);
        idle(5);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        @(negedge CLK); RX_IN = 1'b1;
        expect_out("3c_even_bad", 1'b0, 1'b1, 1'b0, 8'h3C);
        idle(5);

        send_frame(8'hCC, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'hDD, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        @(negedge CLK); RX_IN = 1'b1;
        expect_out("b2b_last", 1'b1, 1'b0, 1'b0, 8'h01);
        @(negedge CLK);
        n = valid_times.size();
        if (n >= 3) begin
            check("b2b_gap1", 32'(valid_times[n-2] - valid_times[n-3]), 32'd352);
            check("b2b_gap2", 32'(valid_times[n-1] - valid_times[n-2]), 32'd352);
        end else begin
            check("b2b_count", 32'(n), 32'd3);
        end
        idle(5);

        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        @(negedge CLK); RX_IN = 1'b1;
        expect_out("55_stop_bad", 1'b0, 1'b0, 1'b1, 8'h01);
        idle(3);
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        @(negedge CLK); RX_IN = 1'b1;
        expect_out("aa_after_stp", 1'b1, 1'b0, 1'b0, 8'hAA);
        idle(5);

        // Two low cycles trigger START, then only the middle vote sample is low.
        glitch_pat = 8'b1110_1100;
        for (int j = 0; j < 8; j++) begin
            @(negedge CLK);
            if (j == 0) PRESCALE = 6'd8;
            RX_IN = glitch_pat[j];
        end
        idle(120);
        expect_out("glitch_quiet", 1'b0, 1'b0, 1'b0, 8'hAA);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        @(negedge CLK); RX_IN = 1'b1;
        expect_out("11_after_glitch", 1'b1, 1'b0, 1'b0, 8'h11);
        idle(5);

        send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        expect_out("mid_reset", 1'b0, 1'b0, 1'b0, 8'h00);
        idle(200);
        send_frame(8'h7E, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        @(negedge CLK); RX_IN = 1'b1;
        expect_out("7e_after_reset", 1'b1, 1'b0, 1'b0, 8'h7E);
        idle(5);

        send_frame(8'hC3, 12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        @(negedge CLK); RX_IN = 1'b1;
        expect_out("illegal_presc", 1'b1, 1'b0, 1'b0, 8'hC3);
        idle(5);

        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        @(negedge CLK); RX_IN = 1'b1;
        expect_out("break", 1'b0, 1'b0, 1'b1, 8'hC3);
        idle(20);

        for (int k = 0; k < 30; k++) begin
            send_frame(8'($urandom), presc_tab[$urandom_range(0, 7)], 1'($urandom), 1'($urandom),
                       1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) != 0), 1'b1, -1);
            n = $urandom_range(0, 3);
            if (n > 0) idle(n);
        end
        idle(400);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
